tradeoff_search_param: RTL and testbench

- Parametrised, handshaked successor to the fixed 20-bit tradeoff search engine.
- For each accepted request (W, mode), it finds the largest N in [0, 2^N_BITS-1] with f(N) <= W.
- Cost functions: mode 0 f(N)=N*N; mode 1 f(N)=N*(N+1)/2.
- Bit-serial binary search, MSB first, one result bit per cycle; sits between the W-vector source and the result consumer with valid/ready on both sides.

---
 rtl/tradeoff_pkg.sv | 19 +
 rtl/tradeoff_cost.sv | 24 ++
 rtl/tradeoff_search_param.sv | 118 +++++++++++
 tb/tb_tradeoff_search_param.sv | 219 +++++++++++++++++++++
 4 files changed

// File: rtl/tradeoff_pkg.sv
// Shared types and helpers for the tradeoff search engine.
// Optional macro: TRADEOFF_EARLY_EXIT_EN (see tradeoff_search_param).
package tradeoff_pkg;

    typedef enum logic [1:0] {
        ST_IDLE   = 2'd0,
        ST_SEARCH = 2'd1,
        ST_DONE   = 2'd2
    } state_e;

    localparam logic MODE_SQUARE = 1'b0;
    localparam logic MODE_TRI    = 1'b1;

    // Width at which cost values are carried so that no product is truncated.
    function automatic int cost_width(input int n_bits);
        return 2 * n_bits + 1;
    endfunction

endpackage

// File: rtl/tradeoff_cost.sv
// Combinational cost function f(cand): cand*cand (square) or cand*(cand+1)/2 (triangular).
module tradeoff_cost
    import tradeoff_pkg::*;
#(
    parameter int N_BITS = 20
) (
    input  logic [N_BITS-1:0]               cand,
    input  logic                            mode,
    output logic [cost_width(N_BITS)-1:0]   cost
);

    localparam int CW = cost_width(N_BITS);

    logic [CW-1:0] c_ext;
    logic [CW-1:0] sq;
    logic [CW-1:0] tri_p;

    // cand*(cand+1) < 2^(2*N_BITS+1), so CW bits hold it before the halving.
    assign c_ext = CW'(cand);
    assign sq    = c_ext * c_ext;
    assign tri_p = c_ext * (c_ext + CW'(1));
    assign cost  = (mode == MODE_TRI) ? (tri_p >> 1) : sq;

endmodule

// File: rtl/tradeoff_search_param.sv
// Bit-serial binary search for the largest N with f(N) <= W, valid/ready on both sides.
// Optional macro TRADEOFF_EARLY_EXIT_EN: stop as soon as f(cand) == W exactly.
module tradeoff_search_param
    import tradeoff_pkg::*;
#(
    parameter int N_BITS = 20,
    parameter int W_BITS = 40
) (
    input  logic                clk,
    input  logic                rst,
    input  logic                in_valid,
    output logic                in_ready,
    input  logic [W_BITS-1:0]   in_w,
    input  logic                in_mode,
    output logic                out_valid,
    input  logic                out_ready,
    output logic [N_BITS-1:0]   out_n,
    output logic                out_sat,
    output logic                busy
);

    localparam int CW = cost_width(N_BITS);
    localparam int IW = (N_BITS > 1) ? $clog2(N_BITS) : 1;

    localparam logic [1:0] IDLE   = ST_IDLE;
    localparam logic [1:0] SEARCH = ST_SEARCH;
    localparam logic [1:0] DONE   = ST_DONE;

    logic [1:0]        state_reg;
    logic [CW-1:0]     w_reg;
    logic              mode_reg;
    logic [N_BITS-1:0] acc_reg;
    logic [IW-1:0]     bit_idx_reg;
    logic [N_BITS-1:0] out_n_reg;
    logic              out_sat_reg;

    logic [N_BITS-1:0] bit_mask;
    logic [N_BITS-1:0] cand;
    logic [N_BITS-1:0] acc_next;
    logic [CW-1:0]     cost;
    logic              fits;
    logic              exact;
    logic              last;

    genvar gi;
    generate
        for (gi = 0; gi < N_BITS; gi++) begin : g_mask
            assign bit_mask[gi] = (bit_idx_reg == IW'(gi));
        end
    endgenerate

    assign cand = acc_reg | bit_mask;

    tradeoff_cost #(.N_BITS(N_BITS)) u_cost (
        .cand (cand),
        .mode (mode_reg),
        .cost (cost)
    );

    assign fits     = (cost <= w_reg);
    assign acc_next = fits ? cand : acc_reg;

`ifdef TRADEOFF_EARLY_EXIT_EN
    // An exact hit means every lower bit would overshoot, so they stay 0.
    assign exact = (cost == w_reg);
`else
    assign exact = 1'b0;
`endif

    assign last = (bit_idx_reg == '0) || exact;

    always_ff @(posedge clk) begin
        if (rst) begin
            state_reg   <= IDLE;
            w_reg       <= '0;
            mode_reg    <= MODE_SQUARE;
            acc_reg     <= '0;
            bit_idx_reg <= '0;
            out_n_reg   <= '0;
            out_sat_reg <= 1'b0;
        end else begin
            case (state_reg)
                IDLE: begin
                    if (in_valid) begin
                        w_reg       <= CW'(in_w);
                        mode_reg    <= in_mode;
                        acc_reg     <= '0;
                        bit_idx_reg <= IW'(N_BITS - 1);
                        state_reg   <= SEARCH;
                    end
                end
                SEARCH: begin
                    acc_reg <= acc_next;
                    if (last) begin
                        out_n_reg   <= acc_next;
                        out_sat_reg <= &acc_next;
                        state_reg   <= DONE;
                    end else begin
                        bit_idx_reg <= bit_idx_reg - IW'(1);
                    end
                end
                DONE: begin
                    if (out_ready) begin
                        state_reg <= IDLE;
                    end
                end
                default: state_reg <= IDLE;
            endcase
        end
    end

    assign in_ready  = (state_reg == IDLE);
    assign out_valid = (state_reg == DONE);
    assign busy      = (state_reg == SEARCH);
    assign out_n     = out_n_reg;
    assign out_sat   = out_sat_reg;

endmodule

// File: tb/tb_tradeoff_search_param.sv
// Bench for tradeoff_search_param: directed table, corner sequences and random requests vs. an arithmetic model.
module tb_tradeoff_search_param;

    localparam int N  = 20;
    localparam int WB = 40;
    localparam longint NMAX = (longint'(1) << N) - 1;

    logic          clk;
    logic          rst;
    logic          in_valid;
    logic          in_ready;
    logic [WB-1:0] in_w;
    logic          in_mode;
    logic          out_valid;
    logic          out_ready;
    logic [N-1:0]  out_n;
    logic          out_sat;
    logic          busy;

    int nvec;
    int nmis;

    tradeoff_search_param #(.N_BITS(N), .W_BITS(WB)) dut (
        .clk       (clk),
        .rst       (rst),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .in_w      (in_w),
        .in_mode   (in_mode),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .out_n     (out_n),
        .out_sat   (out_sat),
        .busy      (busy)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        #5_000_000;
        $display("FAIL watchdog: simulation time limit reached, got hang, expected finish");
        $fatal(1);
    end

    typedef struct {
        logic [WB-1:0] w;
        logic          mode;
        longint        exp_n;
    } vec_t;

    vec_t tbl[7];

    function automatic longint cost_of(input longint n, input bit m);
        return m ? (n * (n + 1)) / 2 : n * n;
    endfunction

    // Closed-form estimate from the inverse of f, then nudged onto the exact integer answer.
    function automatic longint model(input longint w, input bit m);
        longint n;
        if (!m) n = longint'($floor($sqrt(real'(w))));
        else    n = longint'($floor(($sqrt(8.0 * real'(w) + 1.0) - 1.0) / 2.0));
        if (n > NMAX) n = NMAX;
        if (n < 0) n = 0;
        while (n > 0 && cost_of(n, m) > w) n--;
        while (n < NMAX && cost_of(n + 1, m) <= w) n++;
        return n;
    endfunction

    function automatic int full_lat();
`ifdef TRADEOFF_EARLY_EXIT_EN
        return -1;
`else
        return N;
`endif
    endfunction

    task automatic chk(input string name, input longint act, input longint exp);
        nvec++;
        if (act != exp) begin
            nmis++;
            $display("FAIL %s: got %0d, expected %0d", name, act, exp);
        end
    endtask

    // elat = edges after the accept edge until out_valid; negative means only bound it by N.
    task automatic run_req(input string name, input logic [WB-1:0] w, input logic m,
                           input longint en, input int elat);
        int t;
        int lat;
        t = 0;
        while (!in_ready && t < 50) begin
            @(posedge clk); #1;
            t++;
        end
        chk({name, "_in_ready"}, longint'(in_ready), 1);
        in_valid = 1'b1;
        in_w     = w;
        in_mode  = m;
        @(posedge clk); #1;
        in_valid = 1'b0;
        in_w     = WB'({$urandom, $urandom});
        in_mode  = 1'($urandom);
        chk({name, "_busy"}, longint'(busy), 1);
        lat = 0;
        while (!out_valid && lat < 4 * N) begin
            @(posedge clk); #1;
            lat++;
        end
        if (elat >= 0) chk({name, "_latency"}, lat, elat);
        else           chk({name, "_latency_bound"}, longint'(lat <= N), 1);
        chk({name, "_out_n"}, longint'(out_n), en);
        chk({name, "_out_sat"}, longint'(out_sat), longint'(en == NMAX));
        chk({name, "_in_ready_done"}, longint'(in_ready), 0);
        $display("req %s w=%0d mode=%0d -> n=%0d sat=%0d lat=%0d", name, w, m, out_n, out_sat, lat);
        out_ready = 1'b1;
        @(posedge clk); #1;
        out_ready = 1'b0;
        chk({name, "_out_valid_off"}, longint'(out_valid), 0);
        chk({name, "_in_ready_after"}, longint'(in_ready), 1);
    endtask

    initial begin
        logic [WB-1:0] rw;
        logic          rm;
        int            t;
        nvec      = 0;
        nmis      = 0;
        rst       = 1'b1;
        in_valid  = 1'b0;
        in_w      = '0;
        in_mode   = 1'b0;
        out_ready = 1'b0;

        tbl[0] = '{40'd1099509530625, 1'b0, 1048575};
        tbl[1] = '{40'd99,            1'b0, 9};
        tbl[2] = '{40'd0,             1'b0, 0};
        tbl[3] = '{40'hFF_FFFF_FFFF,  1'b0, 1048575};
        tbl[4] = '{40'd10,            1'b1, 4};
        tbl[5] = '{40'd9,             1'b1, 3};
        tbl[6] = '{40'hFF_FFFF_FFFF,  1'b1, 1048575};

        repeat (2) @(posedge clk);
        #1;
        rst = 1'b0;
        chk("reset_in_ready", longint'(in_ready), 1);
        chk("reset_out_valid", longint'(out_valid), 0);
        chk("reset_busy", longint'(busy), 0);
        chk("reset_out_n", longint'(out_n), 0);
        chk("reset_out_sat", longint'(out_sat), 0);

        for (int i = 0; i < 7; i++) begin
            run_req($sformatf("tbl%0d", i), tbl[i].w, tbl[i].mode, tbl[i].exp_n, full_lat());
        end
        run_req("tri_zero", 40'd0, 1'b1, 0, full_lat());

        // Backpressure: result must hold while the consumer stalls.
        in_valid = 1'b1; in_w = 40'd99; in_mode = 1'b0;
        @(posedge clk); #1;
        in_valid = 1'b0;
        t = 0;
        while (!out_valid && t < 4 * N) begin
            @(posedge clk); #1;
            t++;
        end
        for (int c = 0; c < 10; c++) begin
            @(posedge clk); #1;
            chk($sformatf("bp_valid_c%0d", c), longint'(out_valid), 1);
            chk($sformatf("bp_out_n_c%0d", c), longint'(out_n), 9);
            chk($sformatf("bp_in_ready_c%0d", c), longint'(in_ready), 0);
        end
        out_ready = 1'b1;
        @(posedge clk); #1;
        out_ready = 1'b0;
        chk("bp_release_valid", longint'(out_valid), 0);
        chk("bp_release_in_ready", longint'(in_ready), 1);
        $display("req backpressure w=99 mode=0 held 10 cycles n=%0d", out_n);

        // Reset in the middle of a search, at bit index 10.
        in_valid = 1'b1; in_w = 40'hFF_FFFF_FFFF; in_mode = 1'b0;
        @(posedge clk); #1;
        in_valid = 1'b0;
        repeat (9) @(posedge clk);
        #1;
        chk("midrst_busy_before", longint'(busy), 1);
        rst = 1'b1;
        @(posedge clk); #1;
        rst = 1'b0;
        chk("midrst_out_valid", longint'(out_valid), 0);
        chk("midrst_busy", longint'(busy), 0);
        chk("midrst_in_ready", longint'(in_ready), 1);
        chk("midrst_out_n", longint'(out_n), 0);
        $display("req midsearch_reset -> idle");
        run_req("after_rst", 40'd1000000, 1'b0, 1000, full_lat());

        // Reset and a request in the same cycle: reset wins.
        rst = 1'b1; in_valid = 1'b1; in_w = 40'd50; in_mode = 1'b1;
        @(posedge clk); #1;
        rst = 1'b0; in_valid = 1'b0;
        chk("rstwin_busy", longint'(busy), 0);
        chk("rstwin_in_ready", longint'(in_ready), 1);
        $display("req reset_with_valid -> not accepted");

`ifdef TRADEOFF_EARLY_EXIT_EN
        run_req("ee_exact", 40'd274877906944, 1'b0, 524288, 1);
        run_req("ee_miss", 40'd274877906943, 1'b0, 524287, N);
`endif

        for (int i = 0; i < 30; i++) begin
            rw = WB'({$urandom, $urandom}) >> $urandom_range(0, WB - 1);
            rm = 1'($urandom_range(0, 1));
            run_req($sformatf("rnd%0d", i), rw, rm, model(longint'(rw), rm), full_lat());
        end

        $display("== %0d vectors applied, %0d miscompares ==", nvec, nmis);
        $finish;
    end

endmodule
